// File: rtl/rob_multi_pkg.sv
// Shared types for the reorder buffer: opcode classes, entry layout and the
// optional RVFI trace word carried alongside each entry.
package tomasula_types;

   localparam int unsigned ROB_MAX_DEPTH = 32;
   localparam int unsigned ROB_TAG_MAX_W = $clog2(ROB_MAX_DEPTH);

   typedef enum logic [1:0] {
      OP_ALU    = 2'd0,
      OP_LOAD   = 2'd1,
      OP_STORE  = 2'd2,
      OP_BRANCH = 2'd3
   } opcode_short;

   typedef struct packed {
      opcode_short op;
      logic [4:0]  rd;
      logic        done;
      logic        mispred;
   } rob_entry_t;

   typedef struct packed {
      logic [31:0]              pc;
      logic [31:0]              insn;
      logic [ROB_TAG_MAX_W-1:0] rd_tag;
   } rvfi_word;

   // Branches and stores retire without touching the register file.
   function automatic logic writes_rf(input opcode_short op);
      return (op != OP_BRANCH) && (op != OP_STORE);
   endfunction

endpackage

// File: rtl/rob_multi_age_mask.sv
// Marks every occupied slot strictly younger than a given tag, using
// shifted thermometer masks instead of walking the pointer range.
module rob_age_mask
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned TAG_W = $clog2(DEPTH)
) (
   input  logic [TAG_W-1:0] i_head,
   input  logic [TAG_W-1:0] i_tail,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_full,
   output logic [DEPTH-1:0] o_mask
);

   logic [DEPTH-1:0] w_ones;
   logic [DEPTH-1:0] w_ge_head;
   logic [DEPTH-1:0] w_ge_tail;
   logic [DEPTH-1:0] w_le_tag;
   logic [DEPTH-1:0] w_span;
   logic [DEPTH-1:0] w_older;

   assign w_ones    = '1;
   assign w_ge_head = w_ones << i_head;
   assign w_ge_tail = w_ones << i_tail;
   assign w_le_tag  = ~((w_ones << i_tag) << 1);

   // Occupied range [head, tail) and the range [head, tag], each split when it wraps.
   assign w_span  = i_full              ? w_ones :
                    (i_head <= i_tail)  ? (w_ge_head & ~w_ge_tail) :
                                          (w_ge_head | ~w_ge_tail);
   assign w_older = (i_head <= i_tag)   ? (w_ge_head & w_le_tag) :
                                          (w_ge_head | w_le_tag);

   assign o_mask = w_span & ~w_older;

endmodule

// File: rtl/rob_multi.sv
// Multi-commit reorder buffer with in-order retire and mispredict flush.
// Define ROB_RVFI_EN to carry an RVFI trace word per entry to the commit slots.
module rob_multi
   import tomasula_types::*;
#(
   parameter  int unsigned DEPTH    = 8,
   parameter  int unsigned COMMIT_W = 2,
   localparam int unsigned TAG_W    = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             alloc_valid,
   output logic                             alloc_ready,
   input  opcode_short                      alloc_type,
   input  logic [4:0]                       alloc_rd,
   output logic [TAG_W-1:0]                 alloc_tag,
   input  logic [DEPTH-1:0]                 done_vec,
   input  logic                             br_res_valid,
   input  logic [TAG_W-1:0]                 br_res_tag,
   input  logic                             br_res_mispred,
   output logic [COMMIT_W-1:0]              commit_valid,
   output logic [COMMIT_W-1:0]              commit_rf_load,
   output logic [COMMIT_W-1:0][4:0]         commit_rd,
   output logic [COMMIT_W-1:0][TAG_W-1:0]   commit_tag,
   output logic                             flush,
   output logic [DEPTH-1:0]                 squash_mask,
   output logic [TAG_W-1:0]                 head_ptr,
   output logic [TAG_W:0]                   count
`ifdef ROB_RVFI_EN
   ,
   input  rvfi_word                         alloc_rvfi,
   output rvfi_word [COMMIT_W-1:0]          commit_rvfi
`endif
);

   rob_entry_t         r_ent [DEPTH];
   logic [DEPTH-1:0]   r_valid;
   logic [TAG_W-1:0]   r_head;
   logic [TAG_W-1:0]   r_tail;
   logic [TAG_W:0]     r_count;

   logic [TAG_W-1:0]   w_idx [COMMIT_W];
   logic [COMMIT_W-1:0] w_fire;
   logic [TAG_W:0]     w_ncommit;
   logic               w_chain;
   logic               w_flush;
   logic [TAG_W-1:0]   w_br_tag;
   logic               w_full;
   logic               w_xfer;
   logic [DEPTH-1:0]   w_age;

   assign w_full      = (r_count == (TAG_W+1)'(DEPTH));
   assign alloc_ready = ~w_full & ~w_flush;
   assign w_xfer      = alloc_valid & alloc_ready;
   assign alloc_tag   = r_tail;
   assign head_ptr    = r_head;
   assign count       = r_count;
   assign commit_valid = w_fire;
   assign flush       = w_flush;
   assign squash_mask = w_flush ? (w_age & r_valid) : '0;

   // Each slot only fires behind a fired, non-mispredicted older slot.
   always_comb begin
      w_fire         = '0;
      w_ncommit      = '0;
      w_chain        = 1'b1;
      w_flush        = 1'b0;
      w_br_tag       = '0;
      commit_rd      = '0;
      commit_tag     = '0;
      commit_rf_load = '0;
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
         w_idx[k]  = r_head + TAG_W'(k);
         w_fire[k] = w_chain & r_valid[w_idx[k]] & r_ent[w_idx[k]].done;
         if (w_fire[k]) begin
            commit_rd[k]      = r_ent[w_idx[k]].rd;
            commit_tag[k]     = w_idx[k];
            commit_rf_load[k] = writes_rf(r_ent[w_idx[k]].op);
            w_ncommit         = w_ncommit + (TAG_W+1)'(1);
            if (r_ent[w_idx[k]].mispred) begin
               w_flush  = 1'b1;
               w_br_tag = w_idx[k];
            end
         end
         w_chain = w_fire[k] & ~r_ent[w_idx[k]].mispred;
      end
   end

   rob_age_mask #(
      .DEPTH (DEPTH)
   ) u_age_mask (
      .i_head (r_head),
      .i_tail (r_tail),
      .i_tag  (w_br_tag),
      .i_full (w_full),
      .o_mask (w_age)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      end else if (w_flush) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_ent[i].done    <= 1'b0;
            r_ent[i].mispred <= 1'b0;
         end
         r_head  <= w_br_tag + 1'b1;
         r_tail  <= w_br_tag + 1'b1;
         r_count <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (done_vec[i] && r_valid[i]) r_ent[i].done <= 1'b1;
         end
         if (br_res_valid && r_valid[br_res_tag] && (r_ent[br_res_tag].op == OP_BRANCH))
            r_ent[br_res_tag].mispred <= br_res_mispred;
         for (int unsigned k = 0; k < COMMIT_W; k++) begin
            if (w_fire[k]) r_valid[w_idx[k]] <= 1'b0;
         end
         if (w_xfer) begin
            r_valid[r_tail] <= 1'b1;
            r_ent[r_tail]   <= '{op: alloc_type, rd: alloc_rd, done: 1'b0, mispred: 1'b0};
            r_tail          <= r_tail + 1'b1;
         end
         r_head  <= r_head + w_ncommit[TAG_W-1:0];
         r_count <= r_count + (TAG_W+1)'(w_xfer) - w_ncommit;
      end
   end

`ifdef ROB_RVFI_EN
   rvfi_word r_rvfi [DEPTH];
   rvfi_word w_rvfi_in;

   always_comb begin
      w_rvfi_in        = alloc_rvfi;
      w_rvfi_in.rd_tag = ROB_TAG_MAX_W'(r_tail);
      commit_rvfi      = '0;
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
         if (w_fire[k]) commit_rvfi[k] = r_rvfi[w_idx[k]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_rvfi[i] <= '0;
      end else if (w_xfer) begin
         r_rvfi[r_tail] <= w_rvfi_in;
      end
   end
`endif

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi (DEPTH=8, COMMIT_W=2): fill, dual commit,
// blocked commit, wrap, mispredict flush, branch-only resolution, reset mid-flush.
module tb_rob_multi;
   import tomasula_types::*;

   logic              clk;
   logic              rst_n;
   logic              alloc_valid;
   logic              alloc_ready;
   opcode_short       alloc_type;
   logic [4:0]        alloc_rd;
   logic [2:0]        alloc_tag;
   logic [7:0]        done_vec;
   logic              br_res_valid;
   logic [2:0]        br_res_tag;
   logic              br_res_mispred;
   logic [1:0]        commit_valid;
   logic [1:0]        commit_rf_load;
   logic [1:0][4:0]   commit_rd;
   logic [1:0][2:0]   commit_tag;
   logic              flush;
   logic [7:0]        squash_mask;
   logic [2:0]        head_ptr;
   logic [3:0]        count;
`ifdef ROB_RVFI_EN
   rvfi_word          alloc_rvfi;
   rvfi_word [1:0]    commit_rvfi;
   assign alloc_rvfi = '0;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   rob_multi #(
      .DEPTH    (8),
      .COMMIT_W (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_type     (alloc_type),
      .alloc_rd       (alloc_rd),
      .alloc_tag      (alloc_tag),
      .done_vec       (done_vec),
      .br_res_valid   (br_res_valid),
      .br_res_tag     (br_res_tag),
      .br_res_mispred (br_res_mispred),
      .commit_valid   (commit_valid),
      .commit_rf_load (commit_rf_load),
      .commit_rd      (commit_rd),
      .commit_tag     (commit_tag),
      .flush          (flush),
      .squash_mask    (squash_mask),
      .head_ptr       (head_ptr),
      .count          (count)
`ifdef ROB_RVFI_EN
      ,
      .alloc_rvfi     (alloc_rvfi),
      .commit_rvfi    (commit_rvfi)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input opcode_short t, input logic [4:0] rd);
      alloc_valid = 1'b1;
      alloc_type  = t;
      alloc_rd    = rd;
      tick();
      alloc_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b1;
      alloc_valid    = 1'b0;
      alloc_type     = OP_ALU;
      alloc_rd       = '0;
      done_vec       = '0;
      br_res_valid   = 1'b0;
      br_res_tag     = '0;
      br_res_mispred = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_ready",  alloc_ready,  1);
      check("rst_count",  count,        0);
      check("rst_head",   head_ptr,     0);
      check("rst_tag",    alloc_tag,    0);
      check("rst_cvalid", commit_valid, 0);
      check("rst_flush",  flush,        0);
      check("rst_squash", squash_mask,  0);
      #10 rst_n = 1'b1;

      // Fill all eight entries, rd = index + 1
      for (int i = 0; i < 8; i++) begin
         check("fill_tag", alloc_tag, 64'(i));
         alloc(OP_ALU, 5'(i + 1));
      end
      check("full_count", count,       8);
      check("full_ready", alloc_ready, 0);
      alloc_valid = 1'b1;
      tick();
      alloc_valid = 1'b0;
      check("ninth_count", count,     8);
      check("ninth_tail",  alloc_tag, 0);
      check("ninth_head",  head_ptr,  0);

      // Dual commit of entries 0 and 1
      done_vec = 8'b0000_0011;
      tick();
      done_vec = '0;
      check("dual_cvalid", commit_valid,   2'b11);
      check("dual_ctag",   commit_tag,     {3'd1, 3'd0});
      check("dual_crd",    commit_rd,      {5'd2, 5'd1});
      check("dual_rfload", commit_rf_load, 2'b11);
      tick();
      check("dual_head",   head_ptr, 2);
      check("dual_count",  count,    6);

      // Head (2) not done, entry 3 done: nothing retires
      done_vec = 8'b0000_1000;
      tick();
      done_vec = '0;
      check("blocked_cvalid", commit_valid, 0);

      done_vec = 8'b0111_0100;
      tick();
      done_vec = '0;
      check("drain23_cvalid", commit_valid, 2'b11);
      tick();
      check("drain45_cvalid", commit_valid, 2'b11);
      check("drain45_head",   head_ptr,     4);
      tick();
      check("drain6_cvalid",  commit_valid, 2'b01);
      check("drain6_count",   count,        2);
      // Allocate entry 0 while entry 6 retires
      alloc(OP_ALU, 5'd9);
      check("allocommit_count", count,     2);
      check("allocommit_head",  head_ptr,  7);
      check("allocommit_tail",  alloc_tag, 1);

      // Commit group straddling 7 -> 0
      done_vec = 8'b1000_0001;
      tick();
      done_vec = '0;
      check("wrap_cvalid", commit_valid, 2'b11);
      check("wrap_ctag",   commit_tag,   {3'd0, 3'd7});
      check("wrap_crd",    commit_rd,    {5'd9, 5'd8});
      tick();
      check("wrap_head",   head_ptr, 1);
      check("wrap_count",  count,    0);

      // Entries 1 ALU, 2 STORE, 3 BRANCH, 4..6 ALU
      alloc(OP_ALU,    5'd1);
      alloc(OP_STORE,  5'd2);
      alloc(OP_BRANCH, 5'd0);
      alloc(OP_ALU,    5'd4);
      alloc(OP_ALU,    5'd5);
      alloc(OP_ALU,    5'd6);
      check("mp_count", count, 6);
      done_vec       = 8'b0000_0110;
      br_res_valid   = 1'b1;
      br_res_tag     = 3'd3;
      br_res_mispred = 1'b1;
      tick();
      done_vec     = '0;
      br_res_valid = 1'b0;
      check("st_cvalid", commit_valid,   2'b11);
      check("st_rfload", commit_rf_load, 2'b01);
      check("st_flush",  flush,          0);
      tick();
      check("mp_head", head_ptr, 3);
      done_vec = 8'b0000_1000;
      tick();
      done_vec = '0;
      check("mp_flush",  flush,        1);
      check("mp_squash", squash_mask,  8'b0111_0000);
      check("mp_cvalid", commit_valid, 2'b01);
      check("mp_ctag",   commit_tag,   {3'd0, 3'd3});
      check("mp_ready",  alloc_ready,  0);
      alloc(OP_ALU, 5'd1);
      check("post_count", count,     0);
      check("post_head",  head_ptr,  4);
      check("post_tail",  alloc_tag, 4);
      check("post_flush", flush,     0);

      // Mispredict on a non-branch entry must be ignored
      alloc(OP_ALU,    5'd3);
      alloc(OP_BRANCH, 5'd0);
      alloc(OP_ALU,    5'd7);
      br_res_valid   = 1'b1;
      br_res_tag     = 3'd4;
      br_res_mispred = 1'b1;
      tick();
      br_res_tag = 3'd5;
      tick();
      br_res_valid = 1'b0;
      done_vec = 8'b0011_0000;
      tick();
      done_vec = '0;
      check("mp2_cvalid", commit_valid,   2'b11);
      check("mp2_rfload", commit_rf_load, 2'b01);
      check("mp2_flush",  flush,          1);
      check("mp2_squash", squash_mask,    8'b0100_0000);

      // Asynchronous reset inside the flush cycle
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_flush",  flush,          0);
      check("rstmid_squash", squash_mask,    0);
      check("rstmid_cvalid", commit_valid,   0);
      check("rstmid_rfload", commit_rf_load, 0);
      check("rstmid_crd",    commit_rd,      0);
      check("rstmid_ctag",   commit_tag,     0);
      check("rstmid_ready",  alloc_ready,    1);
      check("rstmid_count",  count,          0);
      check("rstmid_head",   head_ptr,       0);
      check("rstmid_tag",    alloc_tag,      0);
      #2 rst_n = 1'b1;
      alloc(OP_ALU, 5'd2);
      check("rel_count", count,     1);
      check("rel_tail",  alloc_tag, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rob_multi.md
ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, 4..32.
REQ-002 SHALL have parameter COMMIT_W, default 2, maximum commits per cycle; 1..4.
REQ-003 SHALL have derived localparam TAG_W = clog2(DEPTH).
REQ-004 SHALL have the following ports: clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 alloc_valid / alloc_ready  in / out  1 / 1  allocation handshake.
REQ-007 alloc_type  in  opcode_short  instruction class.
REQ-008 alloc_rd  in  5  destination, or store source register.
REQ-009 alloc_tag  out  TAG_W  tail index given to the allocating instruction.
REQ-010 done_vec  in  DEPTH  per-entry result-ready strobes.
REQ-011 br_res_valid / br_res_tag / br_res_mispred  in  1 / TAG_W / 1  branch resolution.
REQ-012 commit_valid, commit_rf_load  out  COMMIT_W each  per-slot commit and regfile write enable.
REQ-013 commit_rd / commit_tag  out  COMMIT_W x 5 / COMMIT_W x TAG_W  per-slot commit data.
REQ-014 flush / squash_mask  out  1 / DEPTH  mispredict flush pulse and squashed entries.
REQ-015 head_ptr / count  out  TAG_W / TAG_W+1  occupancy state.

Function
REQ-016 SHALL be a circular buffer; count distinguishes full (count==DEPTH) from empty (0), so all DEPTH entries are usable.
REQ-017 alloc_ready = (count != DEPTH) and not flush; a transfer occurs when alloc_valid and alloc_ready are both high.
REQ-018 A transfer SHALL write entry[tail], clear its done and mispred bits, and increment tail modulo DEPTH.
REQ-019 done_vec[i] SHALL set done[i] at the next edge only if entry i is allocated; otherwise it is ignored.
REQ-020 br_res_valid SHALL record mispred[br_res_tag] only if that entry is an allocated branch; otherwise it is ignored.
REQ-021 Commit slot k (0..COMMIT_W-1) SHALL fire combinationally iff slot k-1 fired, entry head+k is allocated and done, and slot k-1 is not a mispredicted branch.
REQ-022 commit_rf_load[k] SHALL be commit_valid[k] and type not branch/store.
REQ-023 A committing mispredicted branch SHALL assert flush for exactly that cycle.
REQ-024 During a flush cycle, squash_mask SHALL mark every allocated entry younger than the branch.
REQ-025 At the edge ending a flush cycle, all entries SHALL clear, head = tail = branch tag + 1, and count = 0.
REQ-026 Same-cycle allocate and commit of n entries SHALL update count to count + 1 - n.
REQ-027 A done strobe in the same cycle as a commit SHALL be seen from the next cycle onward; no same-cycle bypass.
REQ-028 Pointers SHALL wrap modulo DEPTH; a commit group may straddle index DEPTH-1 to 0.
REQ-029 A flush SHALL override any allocation, done strobe or branch resolution in the same cycle.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously clear all valid, done and mispred bits, head, tail and count.
REQ-031 While in reset, all outputs SHALL be 0 except alloc_ready = 1; this holds when reset is asserted mid-flush.
REQ-032 Reset deassertion SHALL be synchronised externally; the first allocation is accepted on the first edge after release.

Configuration
REQ-033 With ROB_RVFI_EN defined, the block SHALL add input alloc_rvfi (rvfi_word) and output commit_rvfi (COMMIT_W x rvfi_word).
REQ-034 With ROB_RVFI_EN defined, a word SHALL be stored per entry, its rd_tag overwritten with alloc_tag, and presented on its commit slot.
REQ-035 Without ROB_RVFI_EN, no rvfi ports or storage SHALL exist and all other behaviour is identical.

Structure
REQ-036 The rob_entry_t typedef (type, rd, done, mispred) and the ROB_MAX_DEPTH constant SHALL live in tomasula_types, alongside opcode_short.
REQ-037 Sub-module rob_age_mask SHALL compute the DEPTH-bit younger-than-tag mask from head, tail and tag without loops over pointer ranges.

Verification
REQ-038 Fill: DEPTH=8, 8 allocations, no done strobes -> alloc_ready=0, count=8; 9th alloc_valid is ignored.
REQ-039 Dual commit: entries 0,1 done at the same edge -> next cycle commit_valid=2'b11, head advances 0->2.
REQ-040 Wrap: head=7, entries 7 and 0 done -> both commit in one cycle; head=1.
REQ-041 Mispredict: branch at tag 3 plus allocated younger entries 4..6, tag 3 resolved mispredicted and done -> flush=1, squash_mask=8'b0111_0000; next cycle count=0, head=tail=4.
REQ-042 Blocked commit: head not done, entry head+1 done -> commit_valid=0.
REQ-043 Reset mid-flush: rst_n driven low in the flush cycle -> all outputs return to reset values immediately, without waiting for a clock edge.
